bmc_soft_pipe: RTL and testbench

- Parametrised branch metric computer for the Viterbi decoder; successor to the fixed rate-1/2 hard-decision BMC units.
- Accepts one received symbol per beat: N_OUT soft samples, per-lane erasure (puncture) mask, hard/soft mode flag.
- Emits metrics for all 2^N_OUT hypothesis codewords through a registered, backpressure-aware pipeline.
- Sits between the depuncturer and the ACS array, with a symbol index and frame-last tag for traceback control.

---
 rtl/bmc_pkg.sv | 28 ++
 rtl/bmc_lane_dist.sv | 18 +
 rtl/bmc_soft_pipe.sv | 154 +++++++++++++++
 tb/tb_bmc_soft_pipe.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/bmc_pkg.sv
// Shared helpers for the branch metric computer: metric width, hypothesis
// slice offsets and the per-lane distance rule (soft, hard, erased).
package bmc_pkg;

  localparam int BMC_MAX_N_OUT = 4;

  function automatic int bmc_mw(input int soft_w, input int n_out);
    return soft_w + $clog2(n_out);
  endfunction

  function automatic int bmc_hyp_off(input int h, input int mw);
    return h * mw;
  endfunction

  // r is offset-binary: 0 is a strong '0', 2^soft_w-1 a strong '1'.
  function automatic int bmc_lane_dist_f(input int r, input int soft_w,
                                         input logic exp_bit, input logic hard,
                                         input logic erase);
    int msb;
    if (erase) return 0;
    if (hard) begin
      msb = (r >> (soft_w - 1)) & 1;
      return (msb != int'(exp_bit)) ? 1 : 0;
    end
    return exp_bit ? ((1 << soft_w) - 1 - r) : r;
  endfunction

endpackage

// File: rtl/bmc_lane_dist.sv
// One received lane: combinational distance to an expected '0' and to an
// expected '1', honouring hard mode and erasure.
module bmc_lane_dist
  import bmc_pkg::*;
#(
  parameter int SOFT_W = 3
) (
  input  logic [SOFT_W-1:0] i_r,
  input  logic              i_hard,
  input  logic              i_erase,
  output logic [SOFT_W-1:0] o_dist0,
  output logic [SOFT_W-1:0] o_dist1
);

  assign o_dist0 = SOFT_W'(bmc_lane_dist_f(int'(i_r), SOFT_W, 1'b0, i_hard, i_erase));
  assign o_dist1 = SOFT_W'(bmc_lane_dist_f(int'(i_r), SOFT_W, 1'b1, i_hard, i_erase));

endmodule

// File: rtl/bmc_soft_pipe.sv
// Parametrised soft/hard branch metric computer with a valid/ready pipeline.
// Define BMC_NORM_EN to add a third stage that subtracts the minimum metric.
module bmc_soft_pipe
  import bmc_pkg::*;
#(
  parameter int N_OUT  = 2,
  parameter int SOFT_W = 3,
  parameter int CNT_W  = 16
) (
  input  logic                                          clk,
  input  logic                                          rst_n,
  input  logic                                          in_valid,
  output logic                                          in_ready,
  input  logic [N_OUT*SOFT_W-1:0]                       in_soft,
  input  logic [N_OUT-1:0]                              in_erase,
  input  logic                                          in_hard,
  input  logic                                          in_last,
  output logic                                          out_valid,
  input  logic                                          out_ready,
  output logic [(2**N_OUT)*bmc_mw(SOFT_W, N_OUT)-1:0]   out_metric,
  output logic [CNT_W-1:0]                              out_sym_idx,
  output logic                                          out_last
);

  localparam int H  = 2 ** N_OUT;
  localparam int MW = bmc_mw(SOFT_W, N_OUT);

  logic [SOFT_W-1:0] w_d0 [N_OUT];
  logic [SOFT_W-1:0] w_d1 [N_OUT];
  logic [SOFT_W-1:0] r_d0_p1 [N_OUT];
  logic [SOFT_W-1:0] r_d1_p1 [N_OUT];
  logic              r_vld_p1, r_last_p1;
  logic [CNT_W-1:0]  r_idx_p1, r_cnt;
  logic [H*MW-1:0]   w_sum, r_metric_p2;
  logic              r_vld_p2, r_last_p2;
  logic [CNT_W-1:0]  r_idx_p2;
  logic              w_acc, w_adv_p1, w_adv_p2;

  for (genvar k = 0; k < N_OUT; k++) begin : g_lane
    bmc_lane_dist #(.SOFT_W(SOFT_W)) u_dist (
      .i_r     (in_soft[k*SOFT_W +: SOFT_W]),
      .i_hard  (in_hard),
      .i_erase (in_erase[k]),
      .o_dist0 (w_d0[k]),
      .o_dist1 (w_d1[k])
    );
  end

`ifdef BMC_NORM_EN
  logic [MW-1:0]   w_min;
  logic [H*MW-1:0] w_norm, r_metric_p3;
  logic            r_vld_p3, r_last_p3;
  logic [CNT_W-1:0] r_idx_p3;
  logic            w_adv_p3;

  assign w_adv_p3 = !r_vld_p3 || out_ready;
  assign w_adv_p2 = !r_vld_p2 || w_adv_p3;
`else
  assign w_adv_p2 = !r_vld_p2 || out_ready;
`endif
  assign w_adv_p1 = !r_vld_p1 || w_adv_p2;
  assign in_ready = w_adv_p1;
  assign w_acc    = in_valid && in_ready;

  // ---- S1: per-lane distances, symbol index and last tag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p1 <= 1'b0;
      r_cnt    <= '0;
    end else begin
      if (w_adv_p1) r_vld_p1 <= in_valid;
      if (w_acc)    r_cnt    <= in_last ? '0 : r_cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_d0_p1   <= w_d0;
      r_d1_p1   <= w_d1;
      r_idx_p1  <= r_cnt;
      r_last_p1 <= in_last;
    end
  end

  // Bit k of hypothesis h selects which lane-k distance contributes.
  always_comb begin
    w_sum = '0;
    for (int h = 0; h < H; h++) begin
      for (int k = 0; k < N_OUT; k++) begin
        w_sum[bmc_hyp_off(h, MW) +: MW] = w_sum[bmc_hyp_off(h, MW) +: MW]
          + MW'(h[k] ? r_d1_p1[k] : r_d0_p1[k]);
      end
    end
  end

  // ---- S2: per-hypothesis metric sums
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p2    <= 1'b0;
      r_metric_p2 <= '0;
      r_idx_p2    <= '0;
      r_last_p2   <= 1'b0;
    end else if (w_adv_p2) begin
      r_vld_p2 <= r_vld_p1;
      if (r_vld_p1) begin
        r_metric_p2 <= w_sum;
        r_idx_p2    <= r_idx_p1;
        r_last_p2   <= r_last_p1;
      end
    end
  end

`ifdef BMC_NORM_EN
  always_comb begin
    w_min = r_metric_p2[MW-1:0];
    for (int h = 1; h < H; h++) begin
      if (r_metric_p2[bmc_hyp_off(h, MW) +: MW] < w_min)
        w_min = r_metric_p2[bmc_hyp_off(h, MW) +: MW];
    end
    w_norm = '0;
    for (int h = 0; h < H; h++) begin
      w_norm[bmc_hyp_off(h, MW) +: MW] = r_metric_p2[bmc_hyp_off(h, MW) +: MW] - w_min;
    end
  end

  // ---- S3: minimum-normalised metrics
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p3    <= 1'b0;
      r_metric_p3 <= '0;
      r_idx_p3    <= '0;
      r_last_p3   <= 1'b0;
    end else if (w_adv_p3) begin
      r_vld_p3 <= r_vld_p2;
      if (r_vld_p2) begin
        r_metric_p3 <= w_norm;
        r_idx_p3    <= r_idx_p2;
        r_last_p3   <= r_last_p2;
      end
    end
  end

  assign out_valid   = r_vld_p3;
  assign out_metric  = r_metric_p3;
  assign out_sym_idx = r_idx_p3;
  assign out_last    = r_last_p3;
`else
  assign out_valid   = r_vld_p2;
  assign out_metric  = r_metric_p2;
  assign out_sym_idx = r_idx_p2;
  assign out_last    = r_last_p2;
`endif

endmodule

// File: tb/tb_bmc_soft_pipe.sv
// Self-checking bench for bmc_soft_pipe (N_OUT=2, SOFT_W=3, CNT_W=4); follows
// BMC_NORM_EN when it is defined for the build.
`timescale 1ns/1ps
module tb_bmc_soft_pipe;

  localparam int N = 2, SW = 3, CW = 4, MW = 4, H = 4;
`ifdef BMC_NORM_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  logic          clk = 1'b0, rst_n = 1'b0;
  logic          in_valid = 1'b0, in_hard = 1'b0, in_last = 1'b0, out_ready = 1'b1;
  logic [N*SW-1:0] in_soft = '0;
  logic [N-1:0]  in_erase = '0;
  logic          in_ready, out_valid, out_last;
  logic [H*MW-1:0] out_metric;
  logic [CW-1:0] out_sym_idx;

  int n_tests = 0, n_fail = 0;

  always #5 clk = ~clk;

  bmc_soft_pipe #(.N_OUT(N), .SOFT_W(SW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_soft(in_soft), .in_erase(in_erase), .in_hard(in_hard), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_metric(out_metric),
    .out_sym_idx(out_sym_idx), .out_last(out_last)
  );

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Metric of each hypothesis straight from the distance rules.
  function automatic logic [H*MW-1:0] model(input logic [N*SW-1:0] s,
                                            input logic [N-1:0] e, input logic hd);
    int m[H];
    int r, b;
    logic [H*MW-1:0] res;
`ifdef BMC_NORM_EN
    int mn;
`endif
    res = '0;
    for (int h = 0; h < H; h++) begin
      m[h] = 0;
      for (int k = 0; k < N; k++) begin
        r = int'(s[k*SW +: SW]);
        b = (h >> k) & 1;
        if (!e[k]) begin
          if (hd) m[h] += (((r >= (1 << (SW - 1))) ? 1 : 0) != b) ? 1 : 0;
          else    m[h] += (b == 1) ? ((1 << SW) - 1 - r) : r;
        end
      end
    end
`ifdef BMC_NORM_EN
    mn = m[0];
    for (int h = 1; h < H; h++) if (m[h] < mn) mn = m[h];
    for (int h = 0; h < H; h++) m[h] -= mn;
`endif
    for (int h = 0; h < H; h++) res[h*MW +: MW] = MW'(m[h]);
    return res;
  endfunction

  typedef struct {
    logic [H*MW-1:0] m;
    int              idx;
    logic            last;
    int              acc;
  } exp_t;

  exp_t            exp_q[$];
  int              cyc = 0, cnt_m = 0;
  logic            exp_valid, stall_prev = 1'b0, last_prev;
  logic [H*MW-1:0] m_prev;
  logic [CW-1:0]   idx_prev;

  // Scoreboard: beats enter on accept and must emerge in order, LAT edges later at the earliest.
  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      exp_q.delete();
      cnt_m = 0;
      stall_prev = 1'b0;
    end else begin
      exp_valid = (exp_q.size() > 0) && ((cyc - exp_q[0].acc) >= LAT);
      chk("out_valid", out_valid, exp_valid);
      chk("in_ready", in_ready, (exp_q.size() < LAT) || out_ready);
      if (stall_prev) begin
        chk("stall_metric", out_metric, m_prev);
        chk("stall_idx", out_sym_idx, idx_prev);
        chk("stall_last", out_last, last_prev);
      end
      if (out_valid && exp_valid) begin
        chk("sb_metric", out_metric, exp_q[0].m);
        chk("sb_idx", out_sym_idx, exp_q[0].idx);
        chk("sb_last", out_last, exp_q[0].last);
        if (out_ready) void'(exp_q.pop_front());
      end
      stall_prev = out_valid && !out_ready;
      m_prev     = out_metric;
      idx_prev   = out_sym_idx;
      last_prev  = out_last;
      if (in_valid && in_ready) begin
        exp_q.push_back('{m: model(in_soft, in_erase, in_hard), idx: cnt_m, last: in_last, acc: cyc});
        cnt_m = in_last ? 0 : (cnt_m + 1) % (1 << CW);
      end
    end
  end

  logic [N*SW-1:0] t_soft[16];
  logic [N-1:0]    t_erase[16];
  logic            t_hard[16], t_last[16];

  // One beat into an empty pipe with out_ready=1, checked against literals.
  task automatic send_chk(input logic [N*SW-1:0] s, input logic [N-1:0] e, input logic hd,
                          input logic lst, input logic [H*MW-1:0] em, input int eidx,
                          input logic elast);
    in_soft = s; in_erase = e; in_hard = hd; in_last = lst; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
    chk("d_early", out_valid, 1'b0);
    repeat (LAT - 1) @(posedge clk);
    #1;
    chk("d_valid", out_valid, 1'b1);
    chk("d_metric", out_metric, em);
    chk("d_idx", out_sym_idx, eidx);
    chk("d_last", out_last, elast);
    @(posedge clk); #1;
  endtask

  // mode 0: out_ready=1, 1: out_ready=0, 2: random out_ready.
  task automatic push_beats(input int first, input int n, input int mode, input int max_cyc,
                            output int next);
    int   i, c;
    logic acc;
    i = first;
    c = 0;
    while (i < n && c < max_cyc) begin
      in_valid = 1'b1; in_soft = t_soft[i]; in_erase = t_erase[i];
      in_hard = t_hard[i]; in_last = t_last[i];
      if (mode == 1)      out_ready = 1'b0;
      else if (mode == 2) out_ready = 1'($urandom_range(0, 1));
      else                out_ready = 1'b1;
      @(negedge clk);
      acc = in_ready;
      @(posedge clk); #1;
      if (acc) i++;
      c++;
    end
    in_valid = 1'b0; in_last = 1'b0;
    next = i;
  endtask

  task automatic drain(input logic rnd);
    int c;
    c = 0;
    while (exp_q.size() > 0 && c < 500) begin
      out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(posedge clk); #1;
      c++;
    end
    chk("drain_done", exp_q.size(), 0);
    out_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  int              sent;
  logic [H*MW-1:0] em_erase;

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_metric", out_metric, '0);
    chk("rst_idx", out_sym_idx, '0);
    chk("rst_last", out_last, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Pin the model itself against hand-computed values.
    chk("model_soft", model(6'b111_000, 2'b00, 1'b0), 16'h70E7);
    chk("model_hard", model(6'b111_000, 2'b00, 1'b1), 16'h1021);

    send_chk(6'b111_000, 2'b00, 1'b0, 1'b0, 16'h70E7, 0, 1'b0);
    send_chk(6'b111_000, 2'b00, 1'b1, 1'b0, 16'h1021, 1, 1'b0);
`ifdef BMC_NORM_EN
    em_erase = 16'h3030;
`else
    em_erase = 16'h5252;
`endif
    send_chk(6'b000_010, 2'b10, 1'b0, 1'b1, em_erase, 2, 1'b1);

    // Back-to-back beats alternating hard and soft mode.
    t_soft[0] = 6'b101_011; t_soft[1] = 6'b001_110;
    t_soft[2] = 6'b010_010; t_soft[3] = 6'b100_111;
    for (int i = 0; i < 4; i++) begin
      t_hard[i] = (i % 2 == 0); t_erase[i] = 2'b00; t_last[i] = (i == 3);
    end
    push_beats(0, 4, 0, 100, sent);
    chk("alt_sent", sent, 4);
    drain(1'b0);

    // Frame boundary: last on idx 4; the next beat restarts at 0 and also closes a frame.
    for (int i = 0; i < 6; i++)
      send_chk(6'b111_000, 2'b00, 1'b0, 1'(i >= 4), 16'h70E7, (i < 5) ? i : 0, 1'(i >= 4));

    // Backpressure: stalled sink fills the pipe, then a random sink drains it.
    for (int i = 0; i < 10; i++) begin
      t_soft[i]  = 6'((i * 13 + 5) % 64);
      t_erase[i] = 2'((i % 4 == 3) ? 1 : 0);
      t_hard[i]  = (i % 3 == 1);
      t_last[i]  = (i == 9);
    end
    push_beats(0, 10, 1, 8, sent);
    chk("bp_accepts", sent, LAT);
    chk("bp_ready_low", in_ready, 1'b0);
    push_beats(sent, 10, 2, 400, sent);
    chk("bp_all_sent", sent, 10);
    drain(1'b1);

    // Index counter wraps 15 -> 0 with no last.
    for (int i = 0; i < 17; i++)
      send_chk(6'b111_000, 2'b00, 1'b0, 1'b0, 16'h70E7, i % 16, 1'b0);

    // Asynchronous reset with two beats in flight.
    for (int i = 0; i < 2; i++) begin
      t_soft[i] = 6'b011_100; t_erase[i] = 2'b00; t_hard[i] = 1'b0; t_last[i] = 1'b0;
    end
    push_beats(0, 2, 1, 4, sent);
    chk("rf_sent", sent, 2);
    #2 rst_n = 1'b0;
    #1;
    chk("rf_out_valid", out_valid, 1'b0);
    chk("rf_metric", out_metric, '0);
    chk("rf_idx", out_sym_idx, '0);
    chk("rf_last", out_last, 1'b0);
    chk("rf_in_ready", in_ready, 1'b1);
    @(posedge clk); #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    send_chk(6'b111_000, 2'b00, 1'b0, 1'b0, 16'h70E7, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
